pipelined_addsub: RTL

//  Parametrised, pipelined add/subtract unit; successor to the fixed-width combinational adder.

---
 rtl/pipelined_addsub.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined add/subtract unit with carry-chain slicing and valid/ready flow control
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SL = WIDTH / STAGES;

    // Whole pipeline moves together: it only holds when a result is waiting unconsumed.
    logic advance;

    // Values presented to stage k (index 0 = module inputs, index STAGES = output registers).
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_s   [STAGES+1];
    logic             st_c   [STAGES+1];
    logic             st_cm  [STAGES+1];
    logic             st_v   [STAGES+1];
    logic             st_sub [STAGES+1];
    logic             st_sm  [STAGES+1];

    // Subtraction is folded into the operands up front: A + ~B + ~borrow.
    assign st_a[0]   = a;
    assign st_b[0]   = sub ? ~b : b;
    assign st_s[0]   = '0;
    assign st_c[0]   = sub ? ~cin : cin;
    assign st_cm[0]  = 1'b0;
    assign st_v[0]   = in_valid;
    assign st_sub[0] = sub;
    assign st_sm[0]  = signed_mode;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] sum_d, sum_q;
            logic             carry_d, carry_q;
            logic             cmsb_d, cmsb_q;
            logic             valid_d, valid_q;
            logic             sub_d, sub_q;
            logic             sm_d, sm_q;

            // Ripple slice k on top of the partial sum from the previous stage; capture carry into MSB.
            always_comb begin
                logic c;
                logic ai;
                logic bi;
                c       = 1'b0;
                ai      = 1'b0;
                bi      = 1'b0;
                sum_d   = sum_q;
                carry_d = carry_q;
                cmsb_d  = cmsb_q;
                valid_d = valid_q;
                sub_d   = sub_q;
                sm_d    = sm_q;
                if (advance) begin
                    c      = st_c[k];
                    sum_d  = st_s[k];
                    cmsb_d = st_cm[k];
                    for (int j = 0; j < SL; j++) begin
                        ai = st_a[k][k*SL+j];
                        bi = st_b[k][k*SL+j];
                        if (k*SL+j == WIDTH-1) begin
                            cmsb_d = c;
                        end
                        sum_d[k*SL+j] = ai ^ bi ^ c;
                        c = (ai & bi) | (ai & c) | (bi & c);
                    end
                    carry_d = c;
                    valid_d = st_v[k];
                    sub_d   = st_sub[k];
                    sm_d    = st_sm[k];
                end
            end

            // Stage register; reset discards any in-flight operation.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    cmsb_q  <= 1'b0;
                    valid_q <= 1'b0;
                    sub_q   <= 1'b0;
                    sm_q    <= 1'b0;
                end else begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    cmsb_q  <= cmsb_d;
                    valid_q <= valid_d;
                    sub_q   <= sub_d;
                    sm_q    <= sm_d;
                end
            end

            assign st_s[k+1]   = sum_q;
            assign st_c[k+1]   = carry_q;
            assign st_cm[k+1]  = cmsb_q;
            assign st_v[k+1]   = valid_q;
            assign st_sub[k+1] = sub_q;
            assign st_sm[k+1]  = sm_q;

            if (k < STAGES-1) begin : g_ops
                logic [WIDTH-1:0] a_d, a_q;
                logic [WIDTH-1:0] b_d, b_q;

                // Skew the remaining operand bits so later slices see the same op.
                always_comb begin
                    a_d = a_q;
                    b_d = b_q;
                    if (advance) begin
                        a_d = st_a[k];
                        b_d = st_b[k];
                    end
                end

                // Operand skew registers.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end
                end

                assign st_a[k+1] = a_q;
                assign st_b[k+1] = b_q;
            end
        end
    endgenerate

    assign out_valid = st_v[STAGES];
    assign sum       = st_s[STAGES];
    assign cout      = st_c[STAGES];
    assign ovf       = st_sm[STAGES] ? (st_cm[STAGES] ^ st_c[STAGES])
                                     : (st_sub[STAGES] ? ~st_c[STAGES] : st_c[STAGES]);
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;

endmodule
